// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single memory request/ready channel, with a wait timeout.
// ARB_FIXED_PRIO_EN: port 0 always wins contention (default build is round-robin).
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_hit,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_hit,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_hit,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for any request, winner latched on exit
  // ISSUE | mem_req pulsed for one cycle
  // WAIT  | counting cycles until mem_ready or timeout
  // RESP  | granted port sees its ready pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                m0_hit_q, m0_hit_d, m0_err_q, m0_err_d;
  logic                m1_hit_q, m1_hit_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                win;
  logic                cap_en;
  logic                cap_hit, cap_err;
  logic [DATA_W-1:0]   cap_rdata;

`ifdef ARB_FIXED_PRIO_EN
  always_comb win = ~m0_req;
`else
  logic last_q, last_d;

  // The port not granted last wins a tie; a lone requester always wins.
  always_comb win = (m0_req && m1_req) ? ~last_q : m1_req;
  always_comb last_d = cap_en ? gnt_q : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = '0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cap_en      = 1'b0;
    cap_hit     = 1'b0;
    cap_err     = 1'b0;
    cap_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d       = win;
          mem_we_d    = win ? m1_we    : m0_we;
          mem_addr_d  = win ? m1_addr  : m0_addr;
          mem_wdata_d = win ? m1_wdata : m0_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          cap_en    = 1'b1;
          cap_hit   = mem_hit;
          cap_rdata = mem_rdata;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_en  = 1'b1;
          cap_err = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_hit_d   = m0_hit_q;
    m0_err_d   = m0_err_q;
    m0_rdata_d = m0_rdata_q;
    m1_hit_d   = m1_hit_q;
    m1_err_d   = m1_err_q;
    m1_rdata_d = m1_rdata_q;
    if (cap_en && !gnt_q) begin
      m0_hit_d   = cap_hit;
      m0_err_d   = cap_err;
      m0_rdata_d = cap_rdata;
    end
    if (cap_en && gnt_q) begin
      m1_hit_d   = cap_hit;
      m1_err_d   = cap_err;
      m1_rdata_d = cap_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_hit_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_hit_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_hit_q    <= m0_hit_d;
      m0_err_q    <= m0_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_hit_q    <= m1_hit_d;
      m1_err_q    <= m1_err_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ready  = (state_q == RESP) && !gnt_q;
  assign m1_ready  = (state_q == RESP) && gnt_q;
  assign m0_hit    = m0_hit_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_hit    = m1_hit_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized rounds against a
// transaction-order model and a reference memory. Honours ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_ready, m0_hit, m0_err, m1_ready, m1_hit, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_ready, mem_hit;
  logic [DW-1:0] mem_rdata;

  logic drv_ready = 1'b0, drv_hit = 1'b0, stray_ready = 1'b0, stray_hit = 1'b0;
  logic [DW-1:0] drv_rdata = '0, stray_rdata = '0;
  assign mem_ready = drv_ready | stray_ready;
  assign mem_hit   = drv_ready ? drv_hit : stray_hit;
  assign mem_rdata = drv_ready ? drv_rdata : stray_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_hit(m0_hit), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_hit(m1_hit), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_hit(mem_hit), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  txn_t q0[$], q1[$];
  int order[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] bus_mem [int];
  int lg = 1;
  int mem_dly = 1;
  bit in_rst_test = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream memory: answers mem_dly cycles after mem_req, never if mem_dly > TMO.
  initial begin : responder
    txn_t t;
    int d;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
        d = mem_dly;
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          if (!in_rst_test) begin
            if (i == 0) chk("mem_req_one_cycle", 64'(mem_req), 64'd0);
            chk("mem_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(t));
          end
        end
        if (d <= TMO) begin
          if (bus_mem.exists(int'(t.addr))) begin
            drv_rdata = bus_mem[int'(t.addr)]; drv_hit = 1'b1;
          end else begin
            drv_rdata = 32'(t.addr); drv_hit = 1'b0;
          end
          if (t.we) bus_mem[int'(t.addr)] = t.wdata;
          drv_ready = 1'b1;
          @(posedge clk); #1;
          drv_ready = 1'b0;
          drv_rdata = $urandom;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg = 1;
  endtask

  // Serve everything queued in q0/q1; each port re-requests one cycle after its ready.
  task automatic run_round(input int dly);
    int cyc, c0, c1, w, p, e, k, last_p;
    bit first, err, rearm0, rearm1;
    txn_t t;
    logic [DW-1:0] er, last_rd;
    logic eh;
    mem_dly = dly;
    err = (dly > TMO);
    k = err ? TMO : dly;
    order.delete();
    c0 = q0.size(); c1 = q1.size();
    while (c0 > 0 || c1 > 0) begin
      if (c0 > 0 && c1 > 0) begin
`ifdef ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (lg == 1) ? 0 : 1;
`endif
      end else begin
        w = (c0 > 0) ? 0 : 1;
      end
      order.push_back(w);
      lg = w;
      if (w == 0) c0--; else c1--;
    end
    if (q0.size() > 0) begin m0_req = 1'b1; {m0_we, m0_addr, m0_wdata} = q0[0]; end
    if (q1.size() > 0) begin m1_req = 1'b1; {m1_we, m1_addr, m1_wdata} = q1[0]; end
    cyc = 0; first = 1'b1; rearm0 = 1'b0; rearm1 = 1'b0; last_p = 0; last_rd = '0;
    while (order.size() > 0 && cyc < 300) begin
      @(posedge clk); cyc++; #1;
      if (rearm0) begin
        rearm0 = 1'b0;
        if (q0.size() > 0) begin m0_req = 1'b1; {m0_we, m0_addr, m0_wdata} = q0[0]; end
      end
      if (rearm1) begin
        rearm1 = 1'b0;
        if (q1.size() > 0) begin m1_req = 1'b1; {m1_we, m1_addr, m1_wdata} = q1[0]; end
      end
      if (mem_req) begin
        t = (order[0] == 0) ? q0[0] : q1[0];
        chk("mem_issue", 64'({mem_we, mem_addr, mem_wdata}), 64'(t));
      end
      if (m0_ready || m1_ready) begin
        chk("ready_exclusive", 64'(m0_ready & m1_ready), 64'd0);
        p = m1_ready ? 1 : 0;
        e = order.pop_front();
        chk("grant_port", 64'(p), 64'(e));
        t = (e == 0) ? q0.pop_front() : q1.pop_front();
        if (err) begin
          er = '0; eh = 1'b0;
        end else if (ref_mem.exists(int'(t.addr))) begin
          er = ref_mem[int'(t.addr)]; eh = 1'b1;
        end else begin
          er = 32'(t.addr); eh = 1'b0;
        end
        if (!err && t.we) ref_mem[int'(t.addr)] = t.wdata;
        chk("resp_rdata", 64'(p ? m1_rdata : m0_rdata), 64'(er));
        chk("resp_hit",   64'(p ? m1_hit : m0_hit),     64'(eh));
        chk("resp_err",   64'(p ? m1_err : m0_err),     64'(err));
        // counted up to the edge at which the requester samples its ready
        if (first) chk("latency", 64'(cyc + 1), 64'(k + 3));
        first = 1'b0;
        last_p = p; last_rd = p ? m1_rdata : m0_rdata;
        if (p == 0) begin m0_req = 1'b0; rearm0 = 1'b1; end
        else        begin m1_req = 1'b0; rearm1 = 1'b1; end
      end
    end
    chk("round_complete", 64'(order.size()), 64'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rdata", 64'(last_p ? m1_rdata : m0_rdata), 64'(last_rd));
    chk("no_ready_idle", 64'({m0_ready, m1_ready}), 64'd0);
    q0.delete(); q1.delete();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    t.addr = 16'($urandom_range(0, 7) * 4);
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [33:0] s0, s1;
    int n0, n1;
    do_reset();
    chk("rst_m0_outs", 64'({m0_ready, m0_hit, m0_err, m0_rdata}), 64'd0);
    chk("rst_m1_outs", 64'({m1_ready, m1_hit, m1_err, m1_rdata}), 64'd0);
    chk("rst_mem_outs", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);

    // single read of 0x0008, mem answers two cycles after mem_req
    q0.push_back('{we: 1'b0, addr: 16'h0008, wdata: 32'h0});
    run_round(2);

    // m1 write then read of 0x0008
    q1.push_back('{we: 1'b1, addr: 16'h0008, wdata: 32'hAABBCCDD});
    q1.push_back('{we: 1'b0, addr: 16'h0008, wdata: 32'h0});
    run_round(2);
    chk("m1_read_back", 64'(m1_rdata), 64'hAABBCCDD);
    chk("m1_read_hit", 64'(m1_hit), 64'd1);

    // contention right after reset: m0 re-requests once
    do_reset();
    q0.push_back(rnd_txn()); q0.push_back(rnd_txn());
    q1.push_back(rnd_txn());
    run_round(1);

    // timeout, then a normal transaction
    q0.push_back('{we: 1'b0, addr: 16'h000C, wdata: 32'h0});
    run_round(6);
    chk("timeout_err_held", 64'({m0_err, m0_rdata}), 64'h1_0000_0000);
    q0.push_back('{we: 1'b0, addr: 16'h0004, wdata: 32'h0});
    run_round(1);

    // reset while in WAIT; the late mem_ready must be discarded
    in_rst_test = 1'b1;
    mem_dly = 3;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010; m0_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; m0_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    lg = 1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_wait_ready", 64'({m0_ready, m1_ready, mem_req}), 64'd0);
      chk("rst_wait_m0", 64'({m0_hit, m0_err, m0_rdata}), 64'd0);
      chk("rst_wait_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
      @(posedge clk); #1;
    end
    in_rst_test = 1'b0;

    // contention after the mid-wait reset: port 0 must win again
    q0.push_back(rnd_txn()); q1.push_back(rnd_txn());
    run_round(2);

    // stray mem_ready while idle
    s0 = {m0_hit, m0_err, m0_rdata};
    s1 = {m1_hit, m1_err, m1_rdata};
    stray_ready = 1'b1; stray_hit = 1'b1; stray_rdata = $urandom;
    @(posedge clk); #1;
    stray_ready = 1'b0; stray_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stray_m0", 64'({m0_hit, m0_err, m0_rdata}), 64'(s0));
      chk("stray_m1", 64'({m1_hit, m1_err, m1_rdata}), 64'(s1));
      chk("stray_pulses", 64'({m0_ready, m1_ready, mem_req}), 64'd0);
      @(posedge clk); #1;
    end

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) q0.push_back(rnd_txn());
      for (int i = 0; i < n1; i++) q1.push_back(rnd_txn());
      run_round($urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum WAIT cycles before abort; range 1..65535.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. N = 0,1; each line is one port per requester.
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- mN_req, in, 1, level request; held until mN_ready is sampled high.
- mN_we, in, 1, 1 = write, 0 = read.
- mN_addr, in, ADDR_W, request address.
- mN_wdata, in, DATA_W, write data.
- mN_ready, out, 1, one-cycle completion pulse.
- mN_hit, out, 1, downstream hit status, valid with mN_ready.
- mN_rdata, out, DATA_W, read data, valid with mN_ready.
- mN_err, out, 1, timeout abort flag, valid with mN_ready.
- mem_req, out, 1, one-cycle request to the memory system.
- mem_we, out, 1, latched write enable.
- mem_addr, out, ADDR_W, latched address.
- mem_wdata, out, DATA_W, latched write data.
- mem_ready, in, 1, downstream one-cycle completion pulse.
- mem_hit, in, 1, downstream hit.
- mem_rdata, in, DATA_W, downstream read data.

Function
REQ-003 FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE SHALL behave as follows:
- No mN_req high: stay in IDLE.
- Any mN_req high: pick a winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, go to ISSUE.
REQ-005 Winner selection SHALL be round-robin. With both requests high, the port not granted last wins. After reset, port 0 has priority.
REQ-006 In ISSUE, mem_req SHALL be 1 for exactly one cycle; the FSM then goes to WAIT unconditionally.
REQ-007 mem_addr, mem_we and mem_wdata SHALL stay stable from ISSUE through RESP.
REQ-008 In WAIT:
- mem_ready=1: capture mem_hit and mem_rdata, clear err, go to RESP.
- Otherwise: increment a 16-bit wait counter.
- Counter reaches TIMEOUT: set err=1, rdata=0, hit=0, go to RESP.
REQ-009 In RESP, only the granted port SHALL see mN_ready=1, with its captured hit/rdata/err; the FSM returns to IDLE next cycle.
REQ-010 Total latency SHALL be k+3 cycles from the IDLE edge that samples mN_req to the mN_ready pulse, where k = WAIT cycles.
REQ-011 A requester SHALL deassert mN_req on the edge it samples mN_ready. Because the arbiter spends one cycle in RESP, the same transaction is never re-served.
REQ-012 mN_hit, mN_rdata and mN_err SHALL hold their last values outside RESP; only mN_ready is pulsed.
REQ-013 mN_req edges seen outside IDLE SHALL be ignored; the request is served once the FSM returns to IDLE.
REQ-014 mem_ready seen outside WAIT SHALL be ignored.
REQ-015 The last-grant pointer SHALL update only on the transition into RESP.

Reset
REQ-016 rst=1 at a clock edge SHALL force all of the following, regardless of state:
- FSM to IDLE;
- last-grant to port 1 (so port 0 wins first);
- wait counter to 0;
- mem_req, mem_we, mem_addr, mem_wdata to 0;
- mN_ready, mN_hit, mN_rdata, mN_err to 0.
REQ-017 A reset during WAIT SHALL abandon the transaction with no mN_ready pulse. Any later mem_ready from that transaction is discarded per REQ-014.

Configuration
REQ-018 Macro ARB_FIXED_PRIO_EN SHALL select the arbitration policy:
- Defined: port 0 always wins when both request; the last-grant pointer is not implemented.
- Undefined: round-robin per REQ-005.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single read: m0 reads 0x0008; mem_ready two cycles after mem_req with rdata 0x00000008, hit 0. Expect m0_ready with rdata 0x00000008, hit 0, err 0, 5 cycles after request.
- Write then read: m1 writes 0xAABBCCDD to 0x0008, then reads 0x0008 with hit 1. Expect mem_we=1 on the write, then m1_rdata 0xAABBCCDD, m1_hit 1.
- Contention: m0 and m1 request in the same cycle after reset. Round-robin: order m0, m1, m0 on repeated contention. With ARB_FIXED_PRIO_EN: m0 every time until m0 stops requesting.
- Timeout: TIMEOUT=4, mem_ready never asserted. Expect m0_ready with err 1, rdata 0, 7 cycles after request; the next request is served normally.
- Reset mid-WAIT: assert rst during WAIT, then pulse mem_ready late. Expect no mN_ready, all outputs 0, FSM in IDLE.
- Stray ready: mem_ready pulsed in IDLE. Expect no output change.
